// File: rtl/router_mesh_param.sv
// router_mesh_param: 5-port XY mesh router, per-input FIFOs, round-robin outputs.
// Define ROUTER_STATS_EN to add saturating per-output forward counters.
module router_mesh_param #(
  parameter int DATA_WIDTH = 16,
  parameter int MESH_X     = 4,
  parameter int MESH_Y     = 2,
  parameter int ROUTER_X   = 0,
  parameter int ROUTER_Y   = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [5*DATA_WIDTH-1:0] in_data,
  input  logic [4:0]              in_valid,
  output logic [4:0]              in_full_out,
  output logic [5*DATA_WIDTH-1:0] out_data,
  output logic [4:0]              out_valid,
  input  logic [4:0]              out_full_in
`ifdef ROUTER_STATS_EN
  ,
  output logic [5*16-1:0]         stat_fwd_cnt
`endif
);
  localparam int DW = DATA_WIDTH;
  localparam int AX = $clog2(MESH_X);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DW-1:0] RX = DW'(ROUTER_X);
  localparam logic [DW-1:0] RY = DW'(ROUTER_Y);
  localparam logic [DW-1:0] MX = DW'(MESH_X);
  localparam logic [DW-1:0] MY = DW'(MESH_Y);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] FULL_TH = (AW+1)'(FIFO_DEPTH - 1);
  localparam logic [AW:0] ONE_C = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_P = AW'(1);
  localparam logic [4:0] PRESENT = {
    ROUTER_Y != 0, ROUTER_Y != MESH_Y - 1,
    ROUTER_X != 0, ROUTER_X != MESH_X - 1, 1'b1};

  logic [4:0][DW-1:0] w_in;
  logic [4:0][DW-1:0] w_head;
  logic [DW-1:0]      w_dx [5];
  logic [DW-1:0]      w_dy [5];
  logic [DW-1:0]      r_mem [5][FIFO_DEPTH];
  logic [AW-1:0]      r_rd [5];
  logic [AW-1:0]      r_wr [5];
  logic [AW:0]        r_cnt [5];
  logic [2:0]         r_rr [5];
  logic [4:0]         w_req [5];
  logic [2:0]         w_gidx [5];
  logic [2:0]         w_rr_nxt [5];
  logic [4:0]         w_empty;
  logic [4:0]         w_drop;
  logic [4:0]         w_pop;
  logic [4:0]         w_wr;
  logic [4:0]         w_gv;
  logic [4:0][DW-1:0] r_odata;
  logic [4:0]         r_ovalid;

  assign w_in      = in_data;
  assign out_data  = r_odata;
  assign out_valid = r_ovalid;

  // Upper flit bits above the x field form dst_y, so stray high bits
  // mark the flit as out-of-mesh.
  always_comb begin
    for (int p = 0; p < 5; p++) begin
      w_head[p]  = r_mem[p][r_rd[p]];
      w_empty[p] = (r_cnt[p] == '0);
      w_dx[p]    = DW'(w_head[p][AX-1:0]);
      w_dy[p]    = w_head[p] >> AX;
      w_drop[p]  = 1'b0;
      w_req[p]   = '0;
      if (!w_empty[p]) begin
        if (w_dx[p] >= MX || w_dy[p] >= MY) w_drop[p] = 1'b1;
        else if (w_dx[p] > RX) w_req[p][1] = 1'b1;
        else if (w_dx[p] < RX) w_req[p][2] = 1'b1;
        else if (w_dy[p] > RY) w_req[p][3] = 1'b1;
        else if (w_dy[p] < RY) w_req[p][4] = 1'b1;
        else w_req[p][0] = 1'b1;
      end
    end
  end

  always_comb begin : arb
    logic [2:0] idx;
    for (int o = 0; o < 5; o++) begin
      w_gv[o]     = 1'b0;
      w_gidx[o]   = '0;
      w_rr_nxt[o] = r_rr[o];
      for (int k = 0; k < 5; k++) begin
        idx = 3'((32'(r_rr[o]) + k) % 5);
        if (!w_gv[o] && !out_full_in[o] && w_req[idx][o]) begin
          w_gv[o]     = 1'b1;
          w_gidx[o]   = idx;
          w_rr_nxt[o] = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        end
      end
    end
  end

  always_comb begin
    w_pop = w_drop;
    for (int o = 0; o < 5; o++)
      if (w_gv[o]) w_pop[w_gidx[o]] = 1'b1;
  end

  always_comb begin
    for (int p = 0; p < 5; p++) begin
      w_wr[p] = PRESENT[p] && in_valid[p] &&
                (r_cnt[p] != DEPTH || w_pop[p]);
      in_full_out[p] = PRESENT[p] && (r_cnt[p] >= FULL_TH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 5; p++) begin
        r_rd[p]  <= '0;
        r_wr[p]  <= '0;
        r_cnt[p] <= '0;
        for (int e = 0; e < FIFO_DEPTH; e++) r_mem[p][e] <= '0;
      end
    end else begin
      for (int p = 0; p < 5; p++) begin
        if (w_wr[p]) begin
          r_mem[p][r_wr[p]] <= w_in[p];
          r_wr[p] <= r_wr[p] + ONE_P;
        end
        if (w_pop[p]) r_rd[p] <= r_rd[p] + ONE_P;
        if (w_wr[p] && !w_pop[p]) r_cnt[p] <= r_cnt[p] + ONE_C;
        else if (!w_wr[p] && w_pop[p]) r_cnt[p] <= r_cnt[p] - ONE_C;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovalid <= '0;
      r_odata  <= '0;
      for (int o = 0; o < 5; o++) r_rr[o] <= '0;
    end else begin
      for (int o = 0; o < 5; o++) begin
        r_ovalid[o] <= w_gv[o];
        if (w_gv[o]) r_odata[o] <= w_head[w_gidx[o]];
        r_rr[o] <= w_rr_nxt[o];
      end
    end
  end

`ifdef ROUTER_STATS_EN
  logic [4:0][15:0] r_stat;

  assign stat_fwd_cnt = r_stat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat <= '0;
    end else begin
      for (int o = 0; o < 5; o++)
        if (w_gv[o] && r_stat[o] != 16'hFFFF)
          r_stat[o] <= r_stat[o] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_router_mesh_param.sv
// tb_router_mesh_param: routers (1,0) and (0,0) of a 4x2 mesh, directed
// scenarios plus random traffic against a queue-based mesh model.
`timescale 1ns/1ps
module tb_router_mesh_param;
  localparam int DW = 16;
  localparam int MX = 4;
  localparam int MY = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]         vin [2];
  logic [4:0]         fin [2];
  logic [4:0]         fout [2];
  logic [4:0]         ov [2];
  logic [4:0][DW-1:0] din [2];
  logic [4:0][DW-1:0] od [2];

  router_mesh_param #(
    .DATA_WIDTH(DW), .MESH_X(MX), .MESH_Y(MY),
    .ROUTER_X(1), .ROUTER_Y(0), .FIFO_DEPTH(DEPTH)
  ) u_r10 (
    .clk(clk), .rst_n(rst_n),
    .in_data(din[0]), .in_valid(vin[0]), .in_full_out(fout[0]),
    .out_data(od[0]), .out_valid(ov[0]), .out_full_in(fin[0])
  );

  router_mesh_param #(
    .DATA_WIDTH(DW), .MESH_X(MX), .MESH_Y(MY),
    .ROUTER_X(0), .ROUTER_Y(0), .FIFO_DEPTH(DEPTH)
  ) u_r00 (
    .clk(clk), .rst_n(rst_n),
    .in_data(din[1]), .in_valid(vin[1]), .in_full_out(fout[1]),
    .out_data(od[1]), .out_valid(ov[1]), .out_full_in(fin[1])
  );

  int errs = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: node id = y*MX + x, one queue per input port.
  logic [DW-1:0]      mq [2][5][$];
  int                 mrr [2][5];
  logic [4:0]         eov [2];
  logic [4:0][DW-1:0] eod [2];

  function automatic int rpos_x(int n);
    return (n == 0) ? 1 : 0;
  endfunction

  function automatic int route(int f, int rx, int ry);
    int x, y;
    x = f % MX;
    y = f / MX;
    if (y >= MY) return -1;
    if (x > rx) return 1;
    if (x < rx) return 2;
    if (y > ry) return 3;
    if (y < ry) return 4;
    return 0;
  endfunction

  function automatic bit present(int p, int rx, int ry);
    case (p)
      1: return rx != MX - 1;
      2: return rx != 0;
      3: return ry != MY - 1;
      4: return ry != 0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [4:0] mfull(int n);
    logic [4:0] f;
    for (int p = 0; p < 5; p++)
      f[p] = present(p, rpos_x(n), 0) && (mq[n][p].size() >= DEPTH - 1);
    return f;
  endfunction

  task automatic model_step(int n);
    bit popd [5];
    int rx;
    int src;
    rx = rpos_x(n);
    for (int i = 0; i < 5; i++) popd[i] = 1'b0;
    eov[n] = '0;
    for (int o = 0; o < 5; o++) begin
      if (!fin[n][o]) begin
        for (int k = 0; k < 5; k++) begin
          src = (mrr[n][o] + k) % 5;
          if (!eov[n][o] && mq[n][src].size() > 0 &&
              route(int'(mq[n][src][0]), rx, 0) == o) begin
            eov[n][o] = 1'b1;
            eod[n][o] = mq[n][src][0];
            mrr[n][o] = (src + 1) % 5;
            popd[src] = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < 5; i++)
      if (mq[n][i].size() > 0 && route(int'(mq[n][i][0]), rx, 0) < 0)
        popd[i] = 1'b1;
    for (int i = 0; i < 5; i++)
      if (popd[i]) void'(mq[n][i].pop_front());
    for (int i = 0; i < 5; i++)
      if (vin[n][i] && present(i, rx, 0) && mq[n][i].size() < DEPTH)
        mq[n][i].push_back(din[n][i]);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 2; n++) begin
        for (int p = 0; p < 5; p++) begin
          mq[n][p].delete();
          mrr[n][p] = 0;
        end
        eov[n] = '0;
        eod[n] = '0;
      end
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      for (int n = 0; n < 2; n++) begin
        chk($sformatf("valid_r%0d", n), 80'(ov[n]), 80'(eov[n]));
        chk($sformatf("data_r%0d", n), od[n], eod[n]);
        chk($sformatf("full_r%0d", n), 80'(fout[n]), 80'(mfull(n)));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int n = 0; n < 2; n++) begin
      vin[n] = '0;
      din[n] = '0;
      fin[n] = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    logic [DW-1:0] pat [4];
    logic [4:0] pfull [2];
    bit stale;
    int load;
    pat[0] = 16'h3; pat[1] = 16'h7; pat[2] = 16'h2; pat[3] = 16'h6;
    pfull[0] = '0; pfull[1] = '0;
    idle();
    chk("route_east", 80'(route(3, 1, 0)), 80'(1));
    chk("route_west", 80'(route(0, 1, 0)), 80'(2));
    chk("route_north", 80'(route(5, 1, 0)), 80'(3));
    chk("route_oom", 80'(route(8, 1, 0)), 80'(-1));
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_valid", 80'({ov[1], ov[0]}), 80'(0));
    chk("rst_full", 80'({fout[1], fout[0]}), 80'(0));
    rst_n = 1'b1;
    cmp_en = 1'b1;
    cyc();
    @(negedge clk);
    chk("rst_data", {od[1], od[0]}, '0);
    cyc();

    vin[0][0] = 1'b1; din[0][0] = 16'h3; cyc();
    din[0][0] = 16'h0; cyc();
    din[0][0] = 16'h5;
    @(negedge clk);
    chk("t1_east_v", 80'(ov[0]), 80'(5'b00010));
    chk("t1_east_d", 80'(od[0][1]), 80'(16'h3));
    cyc();
    vin[0] = '0; din[0] = '0;
    @(negedge clk);
    chk("t1_west_v", 80'(ov[0]), 80'(5'b00100));
    chk("t1_west_d", 80'(od[0][2]), 80'(16'h0));
    cyc();
    @(negedge clk);
    chk("t1_north_v", 80'(ov[0]), 80'(5'b01000));
    chk("t1_north_d", 80'(od[0][3]), 80'(16'h5));
    cyc();
    @(negedge clk);
    chk("t1_idle", 80'(ov[0]), 80'(0));

    vin[1][1] = 1'b1; din[1][1] = 16'h0; cyc();
    vin[1] = '0;
    @(negedge clk);
    chk("t2_wait", 80'(ov[1]), 80'(0));
    cyc();
    @(negedge clk);
    chk("t2_local_v", 80'(ov[1]), 80'(5'b00001));
    chk("t2_local_d", 80'(od[1][0]), 80'(16'h0));

    do_reset();
    fin[0][1] = 1'b1;
    vin[0] = 5'b01101;
    din[0][0] = 16'h3; din[0][2] = 16'h3; din[0][3] = 16'h3;
    repeat (3) cyc();
    vin[0] = '0;
    @(negedge clk);
    chk("t3_loaded", 80'(fout[0]), 80'(5'b01101));
    fin[0] = '0;
    for (int k = 0; k < 9; k++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("t3_east_%0d", k), 80'(ov[0]), 80'(5'b00010));
      if (k == 0) chk("t3_first_local", 80'(fout[0]), 80'(5'b01100));
      if (k == 1) chk("t3_then_west", 80'(fout[0]), 80'(5'b01000));
      if (k == 2) chk("t3_then_north", 80'(fout[0]), 80'(5'b00000));
    end
    cyc();
    @(negedge clk);
    chk("t3_done", 80'(ov[0]), 80'(0));

    do_reset();
    fin[0][1] = 1'b1;
    vin[0][2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      din[0][2] = pat[k];
      cyc();
      @(negedge clk);
      chk($sformatf("t4_full_%0d", k), 80'(fout[0][2]), 80'(k >= 2));
    end
    vin[0] = '0;
    fin[0] = '0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("t4_drain_v%0d", k), 80'(ov[0]), 80'(5'b00010));
      chk($sformatf("t4_drain_d%0d", k), 80'(od[0][1]), 80'(pat[k]));
    end
    cyc();
    @(negedge clk);
    chk("t4_empty_v", 80'(ov[0]), 80'(0));
    chk("t4_empty_f", 80'(fout[0]), 80'(0));

    do_reset();
    fin[0] = '1;
    vin[0][0] = 1'b1;
    din[0][0] = 16'h0008;
    for (int k = 0; k < 6; k++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("t5_oom_%0d", k), 80'({fout[0], ov[0]}), 80'(0));
    end
    idle();

    do_reset();
    fin[0][1] = 1'b1;
    vin[0][0] = 1'b1;
    din[0][0] = 16'h3;
    repeat (2) cyc();
    vin[0] = '0;
    fin[0] = '0;
    cyc();
    @(negedge clk);
    chk("t6_pre", 80'(ov[0]), 80'(5'b00010));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_v", 80'(ov[0]), 80'(0));
    chk("t6_rst_d", od[0], '0);
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("t6_stale_%0d", k), 80'({fout[0], ov[0]}), 80'(0));
    end

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      stale = (c >= 1500);
      load = 30 + 15 * ((c / 250) % 5);
      for (int n = 0; n < 2; n++) begin
        for (int p = 0; p < 5; p++) begin
          vin[n][p] = (stale ? !pfull[n][p] : !fout[n][p]) &&
                      ($urandom_range(0, 99) < load);
          din[n][p] = ($urandom_range(0, 9) == 0) ?
                      16'(8 + $urandom_range(0, 7)) :
                      16'($urandom_range(0, 7));
          fin[n][p] = ($urandom_range(0, 99) < 25);
        end
        pfull[n] = fout[n];
      end
      cyc();
    end
    idle();
    repeat (10) cyc();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
